// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache that
// sits between the MEM stage and a 256-bit line memory.
// The optional hit/miss statistics counters are built only when the
// DCACHE_STATS_EN macro is defined.
module dcache_controller #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_BITS  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o,
`endif
    input  logic                 mem_ack_i
);

    localparam int TAG_BITS  = 32 - 5 - INDEX_BITS;
    localparam int NUM_LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LINE_BITS-1:0]  line_mem [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic [2:0]            word_sel;
    logic [1:0]            unused_byte_bits;
    logic                  req;
    logic                  is_store;
    logic                  hit;
    logic                  victim_dirty;
    logic                  write_hit;
    logic                  fill_done;
    logic [31:0]           rd_word;
    logic [31:0]           victim_addr;
    logic [31:0]           fill_addr;
    logic [LINE_BITS-1:0]  merged_line;

    assign idx              = cpu_addr_i[5+INDEX_BITS-1:5];
    assign cpu_tag          = cpu_addr_i[31:5+INDEX_BITS];
    assign word_sel         = cpu_addr_i[4:2];
    assign unused_byte_bits = cpu_addr_i[1:0];
    assign req              = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store         = cpu_MemWrite_i;
    assign hit              = valid_q[idx] && (tag_mem[idx] == cpu_tag);
    assign victim_dirty     = valid_q[idx] && dirty_q[idx];
    assign rd_word          = line_mem[idx][{word_sel, 5'b0} +: 32];
    assign victim_addr      = {tag_mem[idx], idx, 5'b0};
    assign fill_addr        = {cpu_tag, idx, 5'b0};
    assign fill_done        = (state_q == ALLOCATE) && mem_enable_o && mem_ack_i;

    // Store data merged into the addressed word of the current line
    always_comb begin
        merged_line = line_mem[idx];
        merged_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
    end

    // State register; reset abandons any outstanding memory transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stall and load-data decode; a miss stalls in the same cycle
    always_comb begin
        state_d     = state_q;
        cpu_stall_o = 1'b0;
        cpu_data_o  = '0;
        write_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (is_store) begin
                            write_hit = 1'b1;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        state_d     = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                if (fill_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered memory request; the enable drops for one cycle between a
    // write-back and the following fetch so the memory sees two requests
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        mem_enable_o <= 1'b1;
                        if (victim_dirty) begin
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= victim_addr;
                            mem_data_o  <= line_mem[idx];
                        end else begin
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= fill_addr;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        mem_addr_o   <= fill_addr;
                    end
                end
                ALLOCATE: begin
                    if (!mem_enable_o) begin
                        mem_enable_o <= 1'b1;
                    end else if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                    end
                end
                default: begin
                    mem_enable_o <= 1'b0;
                end
            endcase
        end
    end

    // Valid/dirty bookkeeping; reset invalidates every line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Line and tag storage, written on a fill or a store hit
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            line_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= cpu_tag;
        end else if (write_hit) begin
            line_mem[idx] <= merged_line;
        end
    end

`ifdef DCACHE_STATS_EN
    // Hit and miss statistics, free-running and wrapping at 2**32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_count_o  <= '0;
            miss_count_o <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit) begin
                hit_count_o <= hit_count_o + 32'd1;
            end else begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed tests for dcache_controller with a small
// fixed-latency line memory driven from the access task.
module tb_dcache_controller;

    logic         clk;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic         mem_en;
    logic         mem_we;
    logic [255:0] mem_rdata;
    logic         mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int vectors;
    int miscompares;

    int           obs_stall;
    logic [31:0]  obs_data;
    int           n_req;
    logic [31:0]  req_addr  [4];
    logic         req_write [4];
    logic [255:0] req_data  [4];

    logic [255:0] fill1;
    logic [255:0] fill2;
    logic [255:0] fill3;

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_enable_o   (mem_en),
        .mem_write_o    (mem_we),
        .mem_data_i     (mem_rdata),
`ifdef DCACHE_STATS_EN
        .hit_count_o    (hit_cnt),
        .miss_count_o   (miss_cnt),
`endif
        .mem_ack_i      (mem_ack)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One CPU access held until the stall clears; memory acks the lat-th
    // cycle that mem_en is seen high and the observed requests are logged
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic is_wr, input int lat, input logic [255:0] fill);
        int   en_cnt;
        logic done;
        en_cnt    = 0;
        done      = 1'b0;
        obs_stall = 0;
        obs_data  = '0;
        n_req     = 0;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_rd    = !is_wr;
        cpu_wr    = is_wr;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (mem_en) begin
                en_cnt++;
                if (en_cnt == lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fill;
                    if (n_req < 4) begin
                        req_addr[n_req]  = mem_addr;
                        req_write[n_req] = mem_we;
                        req_data[n_req]  = mem_wdata;
                    end
                    n_req++;
                    en_cnt = 0;
                end
            end else begin
                en_cnt = 0;
            end
            #1;
            if (cpu_stall) begin
                obs_stall++;
            end else begin
                done     = 1'b1;
                obs_data = cpu_rdata;
            end
            @(negedge clk);
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL access_timeout addr=%h: stall never cleared", addr);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_enable got=%b exp=0", mem_en); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_write got=%b exp=0", mem_we); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        vectors++; if (mem_wdata !== 256'h0) begin miscompares++; $display("[TB] FAIL reset_mem_data got=%h exp=0", mem_wdata[31:0]); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got=%b exp=0", cpu_stall); end
        vectors++; if (cpu_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_cpu_data got=%h exp=0", cpu_rdata); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_miss();
        run_access(32'h0000_0040, 32'h0, 1'b0, 3, fill1);
        vectors++; if (obs_stall !== 4) begin miscompares++; $display("[TB] FAIL rd_miss_stall got=%0d exp=4", obs_stall); end
        vectors++; if (n_req !== 1) begin miscompares++; $display("[TB] FAIL rd_miss_nreq got=%0d exp=1", n_req); end
        vectors++; if (req_addr[0] !== 32'h40) begin miscompares++; $display("[TB] FAIL rd_miss_addr got=%h exp=00000040", req_addr[0]); end
        vectors++; if (req_write[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_miss_write got=%b exp=0", req_write[0]); end
        vectors++; if (obs_data !== 32'h11) begin miscompares++; $display("[TB] FAIL rd_miss_data got=%h exp=00000011", obs_data); end
        #1;
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_miss_enable_drop got=%b exp=0", mem_en); end
    endtask

    task automatic test_write_hit();
        run_access(32'h0000_0044, 32'hDEAD_BEEF, 1'b1, 3, fill1);
        vectors++; if (obs_stall !== 0) begin miscompares++; $display("[TB] FAIL wr_hit_stall got=%0d exp=0", obs_stall); end
        vectors++; if (n_req !== 0) begin miscompares++; $display("[TB] FAIL wr_hit_nreq got=%0d exp=0", n_req); end
        run_access(32'h0000_0044, 32'h0, 1'b0, 3, fill1);
        vectors++; if (obs_stall !== 0) begin miscompares++; $display("[TB] FAIL ld_after_st_stall got=%0d exp=0", obs_stall); end
        vectors++; if (obs_data !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL ld_after_st_data got=%h exp=deadbeef", obs_data); end
        run_access(32'h0000_0048, 32'h0, 1'b0, 3, fill1);
        vectors++; if (obs_data !== 32'h33) begin miscompares++; $display("[TB] FAIL ld_neighbour_data got=%h exp=00000033", obs_data); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] w0;
        logic [31:0] w1;
        run_access(32'h0000_0240, 32'h0, 1'b0, 3, fill2);
        w0 = req_data[0][31:0];
        w1 = req_data[0][63:32];
        vectors++; if (obs_stall !== 8) begin miscompares++; $display("[TB] FAIL evict_stall got=%0d exp=8", obs_stall); end
        vectors++; if (n_req !== 2) begin miscompares++; $display("[TB] FAIL evict_nreq got=%0d exp=2", n_req); end
        vectors++; if (req_addr[0] !== 32'h40) begin miscompares++; $display("[TB] FAIL wb_addr got=%h exp=00000040", req_addr[0]); end
        vectors++; if (req_write[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL wb_write got=%b exp=1", req_write[0]); end
        vectors++; if (w1 !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wb_word1 got=%h exp=deadbeef", w1); end
        vectors++; if (w0 !== 32'h11) begin miscompares++; $display("[TB] FAIL wb_word0 got=%h exp=00000011", w0); end
        vectors++; if (req_addr[1] !== 32'h240) begin miscompares++; $display("[TB] FAIL alloc_addr got=%h exp=00000240", req_addr[1]); end
        vectors++; if (req_write[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL alloc_write got=%b exp=0", req_write[1]); end
        vectors++; if (obs_data !== 32'hA0) begin miscompares++; $display("[TB] FAIL evict_data got=%h exp=000000a0", obs_data); end
    endtask

    task automatic test_store_miss();
        logic [31:0] w0;
        logic [31:0] w1;
        run_access(32'h0000_01E4, 32'hCAFE_F00D, 1'b1, 2, fill3);
        vectors++; if (obs_stall !== 3) begin miscompares++; $display("[TB] FAIL st_miss_stall got=%0d exp=3", obs_stall); end
        vectors++; if (req_addr[0] !== 32'h1E0) begin miscompares++; $display("[TB] FAIL st_miss_addr got=%h exp=000001e0", req_addr[0]); end
        vectors++; if (req_write[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL st_miss_write got=%b exp=0", req_write[0]); end
        run_access(32'h0000_01E4, 32'h0, 1'b0, 2, fill3);
        vectors++; if (obs_data !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL st_merge_data got=%h exp=cafef00d", obs_data); end
        run_access(32'h0000_03E0, 32'h0, 1'b0, 2, fill2);
        w0 = req_data[0][31:0];
        w1 = req_data[0][63:32];
        vectors++; if (obs_stall !== 6) begin miscompares++; $display("[TB] FAIL idx15_evict_stall got=%0d exp=6", obs_stall); end
        vectors++; if (req_addr[0] !== 32'h1E0) begin miscompares++; $display("[TB] FAIL idx15_wb_addr got=%h exp=000001e0", req_addr[0]); end
        vectors++; if (req_write[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL idx15_wb_write got=%b exp=1", req_write[0]); end
        vectors++; if (w1 !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL idx15_wb_word1 got=%h exp=cafef00d", w1); end
        vectors++; if (w0 !== 32'hB0) begin miscompares++; $display("[TB] FAIL idx15_wb_word0 got=%h exp=000000b0", w0); end
        vectors++; if (req_addr[1] !== 32'h3E0) begin miscompares++; $display("[TB] FAIL idx15_alloc_addr got=%h exp=000003e0", req_addr[1]); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        vectors++; if (hit_cnt !== 32'd8) begin miscompares++; $display("[TB] FAIL stats_hits got=%0d exp=8", hit_cnt); end
        vectors++; if (miss_cnt !== 32'd4) begin miscompares++; $display("[TB] FAIL stats_misses got=%0d exp=4", miss_cnt); end
    endtask
`endif

    task automatic test_reset_mid_alloc();
        cpu_addr = 32'h0000_0080;
        cpu_rd   = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_alloc_enable got=%b exp=1", mem_en); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset_enable got=%b exp=0", mem_en); end
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = fill2;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_ack_enable got=%b exp=0", mem_en); end
        vectors++; if (cpu_stall !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_ack_stall got=%b exp=0", cpu_stall); end
        @(negedge clk);
        run_access(32'h0000_0240, 32'h0, 1'b0, 3, fill1);
        vectors++; if (obs_stall !== 4) begin miscompares++; $display("[TB] FAIL reload_stall got=%0d exp=4", obs_stall); end
        vectors++; if (req_write[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_write got=%b exp=0", req_write[0]); end
        vectors++; if (req_addr[0] !== 32'h240) begin miscompares++; $display("[TB] FAIL reload_addr got=%h exp=00000240", req_addr[0]); end
        vectors++; if (obs_data !== 32'h11) begin miscompares++; $display("[TB] FAIL reload_data got=%h exp=00000011", obs_data); end
    endtask

    // Scenario sequence; each test leaves the bench aligned to a falling edge
    initial begin
        vectors     = 0;
        miscompares = 0;
        fill1 = {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        fill2 = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
        fill3 = {32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_evict();
        test_store_miss();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        test_reset_mid_alloc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
